exec_unit: RTL and testbench
============================

# exec_unit

Execution unit of the 8-bit CPU datapath: an 8-bit ALU with a carry flag, a compare/branch condition evaluator, and an 8-bit free-running timer. It sits between operand buses A/B and result bus C. The ALU drives the result, the condition evaluator drives the program-counter write/CALL/RET decision, and the timer is the readable/writable register at address 14.

## Interface
Parameters:
- `WIDTH`, default 8: operand, result and timer width.

Ports (name, direction, width, meaning):
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `para_a` input WIDTH: operand A.
- `para_b` input WIDTH: operand B.
- `opcode` input 8: instruction byte.
  - [7] A is an immediate (ignored here).
  - [6] B is an immediate (ignored here).
  - [5:4] class: 00 ALU, 01 RAM, 10 COND, 11 reserved.
  - [3:0] function code.
- `en_alu` input 1: ALU operation this cycle.
- `en_cond` input 1: condition operation this cycle.
- `alu_o` output WIDTH: ALU result. 0 when `en_alu`=0.
- `carry_o` output 1: current carry/borrow flag.
- `cond_o` output 1: condition result. 0 when `en_cond`=0.
- `tmr_tick` input 1: one-cycle timer increment strobe.
- `tmr_we` input 1: timer load strobe.
- `tmr_din` input WIDTH: timer load value.
- `tmr_q` output WIDTH: timer value.

## Operation
- The ALU is combinational from `para_a`, `para_b`, `opcode[3:0]` and the carry flag. Function codes:
  - 0 ADD
  - 1 SUB (A−B)
  - 2 AND
  - 3 OR
  - 4 NOT A
  - 5 XOR
  - 6 SHL A by B[2:0]
  - 7 SHR A by B[2:0] (logical)
  - 8 MUL (low byte)
  - 9 DIV (A/B)
  - A MOD (A%B)
  - B ADC (A+B+C)
  - C SBB (A−B−C)
  - D–F: result 0.
- Division by zero: DIV returns all-ones, MOD returns A.
- Carry flag:
  - ADD/ADC set it to the carry out of bit WIDTH−1.
  - SUB/SBB set it to the borrow (1 when the unsigned A < B+cin).
  - All other codes leave it unchanged.
- The condition evaluator is combinational. `opcode[3]`=1 selects a signed compare, 0 an unsigned compare. `opcode[2:0]`:
  - 0 EQ
  - 1 NE
  - 2 LT (A<B)
  - 3 LE
  - 4 GT
  - 5 GE
  - 6 CALL: always 1
  - 7 RET: always 0
- The CPU forms its PC mode as {opcode[2:1]==11, cond_o}. So CALL gives 11 and RET gives 10.
- Timer:
  - Load (`tmr_we`) has priority over `tmr_tick`.
  - A tick increments the value modulo 2^WIDTH, so 255 wraps to 0.
  - With neither strobe, the value holds.
- Results of `en_alu` and `en_cond` are independent. If both are high, both outputs are valid; the controller never issues this.

## Timing
- `alu_o`, `cond_o`: zero-latency combinational.
- Carry flag: registered. It updates on the rising `clk` edge while `en_alu`=1 with a carry-affecting code.
  - The new value is visible to the next cycle's ADC/SBB.
- Timer: registered. A load or tick takes effect on the rising edge where the strobe is sampled high; `tmr_q` shows it the same cycle after the edge.
- Reset (`rst`=0, asynchronous): carry = 0 and `tmr_q` = 0 immediately.
  - Combinational outputs follow their inputs.
  - Reset asserted mid-sequence discards the pending carry.
  - Strobes are ignored while reset is held.

## Configuration
- `EXEC_MULDIV_EN`:
  - Defined: codes 8/9/A implement MUL/DIV/MOD as above.
  - Undefined: codes 8/9/A return 0, leave carry unchanged, and no multiplier/divider logic is synthesized.

## Test plan
- ALU chain: ADD 0xF0+0x20 → `alu_o`=0x10 and carry=1. Next cycle ADC 0x01+0x00 → 0x02 and carry=0.
- SUB 0x05−0x07 → 0xFE, carry=1. Then SBB 0x10−0x00 → 0x0F.
- Conditions:
  - Unsigned LT A=0x80, B=0x01 → 0; signed LT (opcode[3]=1) → 1.
  - EQ 0x33/0x33 → 1.
  - CALL → 1 and RET → 0 regardless of operands.
  - `en_cond`=0 → 0.
- DIV/MOD (macro on): 0x64/0x07 → DIV 0x0E, MOD 0x02. Divide by zero → DIV 0xFF, MOD returns A.
  - Macro off: DIV returns 0.
- Timer:
  - Load 0xFE, then 2 ticks → 0xFF, then 0x00.
  - Simultaneous load 0x55 and tick → 0x55.
- Reset: after ADD with carry, assert `rst` asynchronously between edges → carry and `tmr_q` read 0 before the next edge.

Source files
------------

// File: rtl/exec_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_unit_if                                                         |
// | Operand/result/condition/timer bundle between the controller and     |
// | the execution unit.                                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface exec_unit_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] para_a;
  logic [WIDTH-1:0] para_b;
  logic [7:0]       opcode;
  logic             en_alu;
  logic             en_cond;
  logic [WIDTH-1:0] alu_o;
  logic             carry_o;
  logic             cond_o;
  logic             tmr_tick;
  logic             tmr_we;
  logic [WIDTH-1:0] tmr_din;
  logic [WIDTH-1:0] tmr_q;

  // Controller side: issues operands and strobes, reads results.
  modport master (
    output para_a, para_b, opcode, en_alu, en_cond, tmr_tick, tmr_we, tmr_din,
    input  alu_o, carry_o, cond_o, tmr_q
  );

  // Execution unit side.
  modport slave (
    input  para_a, para_b, opcode, en_alu, en_cond, tmr_tick, tmr_we, tmr_din,
    output alu_o, carry_o, cond_o, tmr_q
  );
endinterface
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_unit                                                            |
// | 8-bit CPU execution unit: ALU with carry flag, compare/branch        |
// | condition evaluator and a free-running loadable timer.               |
// | Optional feature macro: EXEC_MULDIV_EN (MUL/DIV/MOD on codes 8/9/A). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module exec_unit #(
  parameter int WIDTH = 8
) (
  input  wire logic   clk,
  input  wire logic   rst,
  exec_unit_if.slave  bus
);

  logic             carry_q;
  logic             carry_d;
  logic [WIDTH-1:0] tmr_q;
  logic [WIDTH-1:0] tmr_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_aff;
  logic             cond_res;
  logic             cond_lt;
  logic             cond_eq;

  // Operand class and immediate flags are decoded by the controller.
  wire unused_ok = &{1'b0, bus.opcode[7:4]};

  // Add/subtract share a WIDTH+1 datapath so the top bit is carry/borrow.
  // A negative difference always sets the top bit, which is the borrow.
  logic [WIDTH:0] add_w, adc_w, sub_w, sbb_w;
  assign add_w = {1'b0, bus.para_a} + {1'b0, bus.para_b};
  assign adc_w = add_w + {{WIDTH{1'b0}}, carry_q};
  assign sub_w = {1'b0, bus.para_a} - {1'b0, bus.para_b};
  assign sbb_w = sub_w - {{WIDTH{1'b0}}, carry_q};

  // ALU result and carry candidate for the current function code.
  always_comb begin
    alu_res  = '0;
    alu_cout = carry_q;
    alu_aff  = 1'b0;
    case (bus.opcode[3:0])
      4'h0: begin alu_res = add_w[WIDTH-1:0]; alu_cout = add_w[WIDTH]; alu_aff = 1'b1; end
      4'h1: begin alu_res = sub_w[WIDTH-1:0]; alu_cout = sub_w[WIDTH]; alu_aff = 1'b1; end
      4'h2: alu_res = bus.para_a & bus.para_b;
      4'h3: alu_res = bus.para_a | bus.para_b;
      4'h4: alu_res = ~bus.para_a;
      4'h5: alu_res = bus.para_a ^ bus.para_b;
      4'h6: alu_res = bus.para_a << bus.para_b[2:0];
      4'h7: alu_res = bus.para_a >> bus.para_b[2:0];
`ifdef EXEC_MULDIV_EN
      4'h8: alu_res = bus.para_a * bus.para_b;
      4'h9: alu_res = (bus.para_b == '0) ? {WIDTH{1'b1}} : bus.para_a / bus.para_b;
      4'hA: alu_res = (bus.para_b == '0) ? bus.para_a : bus.para_a % bus.para_b;
`else
      4'h8, 4'h9, 4'hA: alu_res = '0;
`endif
      4'hB: begin alu_res = adc_w[WIDTH-1:0]; alu_cout = adc_w[WIDTH]; alu_aff = 1'b1; end
      4'hC: begin alu_res = sbb_w[WIDTH-1:0]; alu_cout = sbb_w[WIDTH]; alu_aff = 1'b1; end
      default: alu_res = '0;
    endcase
  end

  // Carry only moves on an enabled add/subtract-family operation.
  always_comb begin
    carry_d = carry_q;
    if (bus.en_alu && alu_aff) carry_d = alu_cout;
  end

  // Carry flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) carry_q <= 1'b0;
    else      carry_q <= carry_d;
  end

  // Condition evaluator; opcode[3] picks signed versus unsigned ordering.
  always_comb begin
    cond_eq  = (bus.para_a == bus.para_b);
    cond_lt  = bus.opcode[3] ? ($signed(bus.para_a) < $signed(bus.para_b))
                             : (bus.para_a < bus.para_b);
    cond_res = 1'b0;
    case (bus.opcode[2:0])
      3'd0: cond_res = cond_eq;
      3'd1: cond_res = !cond_eq;
      3'd2: cond_res = cond_lt;
      3'd3: cond_res = cond_lt | cond_eq;
      3'd4: cond_res = !(cond_lt | cond_eq);
      3'd5: cond_res = !cond_lt;
      3'd6: cond_res = 1'b1;
      default: cond_res = 1'b0;
    endcase
  end

  // Timer next value: load wins over tick, otherwise hold.
  always_comb begin
    tmr_d = tmr_q;
    if (bus.tmr_we)        tmr_d = bus.tmr_din;
    else if (bus.tmr_tick) tmr_d = tmr_q + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  // Timer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmr_q <= '0;
    else      tmr_q <= tmr_d;
  end

  assign bus.alu_o   = bus.en_alu ? alu_res : '0;
  assign bus.cond_o  = bus.en_cond & cond_res;
  assign bus.carry_o = carry_q;
  assign bus.tmr_q   = tmr_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exec_unit                                                         |
// | Directed and random checks of exec_unit against an arithmetic model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_exec_unit;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  int   m_carry;
  int   m_tmr;
  int   p_alu, p_cond;

  exec_unit_if #(.WIDTH(8)) bus ();

  exec_unit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference of the ALU on plain integers.
  function automatic void alu_ref(input int a, input int b, input int f, input int cin,
                                  output int res, output int cout, output bit aff);
    res  = 0;
    cout = cin;
    aff  = 1'b0;
    case (f)
      0:  begin res = (a + b) % 256; cout = (a + b > 255) ? 1 : 0; aff = 1; end
      1:  begin res = (a - b + 256) % 256; cout = (a < b) ? 1 : 0; aff = 1; end
      2:  res = a & b;
      3:  res = a | b;
      4:  res = 255 - a;
      5:  res = a ^ b;
      6:  res = (a * (1 << (b % 8))) % 256;
      7:  res = a / (1 << (b % 8));
`ifdef EXEC_MULDIV_EN
      8:  res = (a * b) % 256;
      9:  res = (b == 0) ? 255 : a / b;
      10: res = (b == 0) ? a : a % b;
`endif
      11: begin res = (a + b + cin) % 256; cout = (a + b + cin > 255) ? 1 : 0; aff = 1; end
      12: begin res = (a - b - cin + 512) % 256; cout = (a < b + cin) ? 1 : 0; aff = 1; end
      default: res = 0;
    endcase
  endfunction

  function automatic int cond_ref(input int a, input int b, input int op);
    int sa, sb;
    sa = a; sb = b;
    if (op & 8) begin
      if (a >= 128) sa = a - 256;
      if (b >= 128) sb = b - 256;
    end
    case (op % 8)
      0: return (sa == sb) ? 1 : 0;
      1: return (sa != sb) ? 1 : 0;
      2: return (sa <  sb) ? 1 : 0;
      3: return (sa <= sb) ? 1 : 0;
      4: return (sa >  sb) ? 1 : 0;
      5: return (sa >= sb) ? 1 : 0;
      6: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic drive(input int a, input int b, input int op, input bit ea, input bit ec,
                       input bit tick, input bit we, input int din);
    bus.para_a   = 8'(a);
    bus.para_b   = 8'(b);
    bus.opcode   = 8'(op);
    bus.en_alu   = ea;
    bus.en_cond  = ec;
    bus.tmr_tick = tick;
    bus.tmr_we   = we;
    bus.tmr_din  = 8'(din);
  endtask

  // One clock: check combinational outputs, then registered state after the edge.
  task automatic step(input int a, input int b, input int op, input bit ea, input bit ec,
                      input bit tick, input bit we, input int din);
    int res, cout, ecnd;
    bit aff;
    drive(a, b, op, ea, ec, tick, we, din);
    #2;
    alu_ref(a, b, op % 16, m_carry, res, cout, aff);
    ecnd = ec ? cond_ref(a, b, op % 16) : 0;
    chk("alu", 32'(bus.alu_o), ea ? 32'(res) : 32'd0);
    chk("cond", 32'(bus.cond_o), 32'(ecnd));
    @(posedge clk);
    #1;
    if (ea && aff) m_carry = cout;
    if (we)        m_tmr = din;
    else if (tick) m_tmr = (m_tmr + 1) % 256;
    chk("carry", 32'(bus.carry_o), 32'(m_carry));
    chk("tmr", 32'(bus.tmr_q), 32'(m_tmr));
  endtask

  // Apply operands briefly, capture outputs, then idle through one edge.
  task automatic peek(input int a, input int b, input int op, input bit ea, input bit ec);
    drive(a, b, op, ea, ec, 1'b0, 1'b0, 0);
    #1;
    p_alu  = int'(bus.alu_o);
    p_cond = int'(bus.cond_o);
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    m_carry = 0;
    m_tmr = 0;
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    #1;
    chk("rst_carry", 32'(bus.carry_o), 32'd0);
    chk("rst_tmr", 32'(bus.tmr_q), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // ALU chain with carry
    step(8'hF0, 8'h20, 8'h00, 1, 0, 0, 0, 0);
    chk("tp_add_carry", 32'(bus.carry_o), 32'd1);
    peek(8'h01, 8'h00, 8'h0B, 1, 0);
    chk("tp_adc_res", 32'(p_alu), 32'h02);
    step(8'h01, 8'h00, 8'h0B, 1, 0, 0, 0, 0);
    chk("tp_adc_carry", 32'(bus.carry_o), 32'd0);
    peek(8'h05, 8'h07, 8'h01, 1, 0);
    chk("tp_sub_res", 32'(p_alu), 32'hFE);
    step(8'h05, 8'h07, 8'h01, 1, 0, 0, 0, 0);
    chk("tp_sub_carry", 32'(bus.carry_o), 32'd1);
    peek(8'h10, 8'h00, 8'h0C, 1, 0);
    chk("tp_sbb_res", 32'(p_alu), 32'h0F);
    step(8'h10, 8'h00, 8'h0C, 1, 0, 0, 0, 0);

    // Conditions
    peek(8'h80, 8'h01, 8'h22, 0, 1);
    chk("tp_ult", 32'(p_cond), 32'd0);
    peek(8'h80, 8'h01, 8'h2A, 0, 1);
    chk("tp_slt", 32'(p_cond), 32'd1);
    peek(8'h33, 8'h33, 8'h20, 0, 1);
    chk("tp_eq", 32'(p_cond), 32'd1);
    peek(8'h12, 8'h99, 8'h26, 0, 1);
    chk("tp_call", 32'(p_cond), 32'd1);
    peek(8'h33, 8'h33, 8'h27, 0, 1);
    chk("tp_ret", 32'(p_cond), 32'd0);
    peek(8'h33, 8'h33, 8'h20, 0, 0);
    chk("tp_cond_off", 32'(p_cond), 32'd0);
    peek(8'h33, 8'h33, 8'h00, 0, 0);
    chk("tp_alu_off", 32'(p_alu), 32'd0);

    // Multiply/divide
`ifdef EXEC_MULDIV_EN
    peek(8'h64, 8'h07, 8'h09, 1, 0);
    chk("tp_div", 32'(p_alu), 32'h0E);
    peek(8'h64, 8'h07, 8'h0A, 1, 0);
    chk("tp_mod", 32'(p_alu), 32'h02);
    peek(8'h64, 8'h00, 8'h09, 1, 0);
    chk("tp_div0", 32'(p_alu), 32'hFF);
    peek(8'h64, 8'h00, 8'h0A, 1, 0);
    chk("tp_mod0", 32'(p_alu), 32'h64);
`else
    peek(8'h64, 8'h07, 8'h09, 1, 0);
    chk("tp_div_off", 32'(p_alu), 32'h00);
    peek(8'h05, 8'h07, 8'h08, 1, 0);
    chk("tp_mul_off", 32'(p_alu), 32'h00);
`endif

    // Timer
    step(0, 0, 0, 0, 0, 0, 1, 8'hFE);
    chk("tp_tmr_load", 32'(bus.tmr_q), 32'hFE);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("tp_tmr_ff", 32'(bus.tmr_q), 32'hFF);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("tp_tmr_wrap", 32'(bus.tmr_q), 32'h00);
    step(0, 0, 0, 0, 0, 1, 1, 8'h55);
    chk("tp_tmr_prio", 32'(bus.tmr_q), 32'h55);

    // Asynchronous reset between edges
    step(8'hF0, 8'h20, 8'h00, 1, 0, 1, 0, 0);
    chk("tp_pre_rst_carry", 32'(bus.carry_o), 32'd1);
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_carry", 32'(bus.carry_o), 32'd0);
    chk("async_rst_tmr", 32'(bus.tmr_q), 32'd0);
    m_carry = 0;
    m_tmr = 0;
    drive(8'h01, 8'h02, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAA);
    #1;
    chk("rst_alu_comb", 32'(bus.alu_o), 32'h03);
    @(posedge clk);
    #1;
    chk("rst_strobe_ign", 32'(bus.tmr_q), 32'd0);
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      int a, b;
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      if ($urandom_range(0, 5) == 0) b = a;
      step(a, b, $urandom_range(0, 255), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 255));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
